// File: rtl/ahb_apb_bridge_param_if.sv
// Bus bundle between the AHB-Lite side and the APB side of the bridge.
// Handshake: an AHB transfer is accepted when Hreadyout & Hreadyin & Htrans[1];
// an APB access completes on the cycle Penable & Pready are both high.
interface ahb_apb_bridge_param_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4
);
  logic              Hwrite;
  logic              Hreadyin;
  logic [1:0]        Htrans;
  logic [ADDR_W-1:0] Haddr;
  logic [DATA_W-1:0] Hwdata;
  logic [DATA_W-1:0] Hrdata;
  logic [1:0]        Hresp;
  logic              Hreadyout;
  logic [ADDR_W-1:0] Paddr;
  logic [DATA_W-1:0] Pwdata;
  logic [DATA_W-1:0] Prdata;
  logic [NUM_SLV-1:0] Pselx;
  logic              Pwrite;
  logic              Penable;
  logic              Pready;
  logic              Pslverr;

  modport slave (
    input  Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata, Pready, Pslverr,
    output Hrdata, Hresp, Hreadyout, Paddr, Pwdata, Pselx, Pwrite, Penable
  );

  modport master (
    output Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata, Pready, Pslverr,
    input  Hrdata, Hresp, Hreadyout, Paddr, Pwdata, Pselx, Pwrite, Penable
  );
endinterface

// File: rtl/ahb_apb_bridge_param.sv
// Parametrised AHB-Lite to APB bridge: one transfer in flight, PREADY wait states,
// PSLVERR and decode errors mapped to a two-cycle AHB ERROR, optional access timeout.
module ahb_apb_bridge_param #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 0
) (
  input  logic                   Hclk,
  input  logic                   Hresetn,
  ahb_apb_bridge_param_if.slave  bus,
  output logic [2:0]             dbg_state
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LATCH  = 3'd1,
    S_SETUP  = 3'd2,
    S_ACCESS = 3'd3,
    S_ERR1   = 3'd4,
    S_ERR2   = 3'd5
  } state_e;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [NUM_SLV-1:0] SEL_ONE  = NUM_SLV'(1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  haddr_q, haddr_d;
  logic               hwrite_q, hwrite_d;
  logic [3:0]         idx_q, idx_d;
  logic [ADDR_W-1:0]  paddr_q, paddr_d;
  logic               pwrite_q, pwrite_d;
  logic [DATA_W-1:0]  pwdata_q, pwdata_d;
  logic [NUM_SLV-1:0] psel_q, psel_d;
  logic               penable_q, penable_d;
  logic [DATA_W-1:0]  hrdata_q, hrdata_d;
  logic               err_q, err_d;
  logic               hready_q, hready_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid;
  logic               unused_htrans0;

  assign unused_htrans0 = bus.Htrans[0];
  assign valid = hready_q & bus.Hreadyin & bus.Htrans[1];

  always_comb begin
    state_d   = state_q;
    haddr_d   = haddr_q;
    hwrite_d  = hwrite_q;
    idx_d     = idx_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    hrdata_d  = hrdata_q;
    err_d     = err_q;
    hready_d  = hready_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE, S_ERR2: begin
        // ERR2 is the second ERROR cycle and doubles as an address-phase sampler.
        err_d    = 1'b0;
        hready_d = 1'b1;
        state_d  = S_IDLE;
        if (valid) begin
          haddr_d  = bus.Haddr;
          hwrite_d = bus.Hwrite;
          idx_d    = bus.Haddr[SEL_LSB +: 4];
          hready_d = 1'b0;
          state_d  = S_LATCH;
        end
      end
      S_LATCH: begin
        if (hwrite_q) pwdata_d = bus.Hwdata;
        if (int'(idx_q) >= NUM_SLV) begin
          err_d   = 1'b1;
          state_d = S_ERR1;
        end else begin
          psel_d   = SEL_ONE << idx_q;
          paddr_d  = haddr_q;
          pwrite_d = hwrite_q;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (bus.Pready) begin
          psel_d    = '0;
          penable_d = 1'b0;
          if (bus.Pslverr) begin
            err_d   = 1'b1;
            state_d = S_ERR1;
          end else begin
            hready_d = 1'b1;
            if (!pwrite_q) hrdata_d = bus.Prdata;
            state_d  = S_IDLE;
          end
        end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
          psel_d    = '0;
          penable_d = 1'b0;
          err_d     = 1'b1;
          state_d   = S_ERR1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ERR1: begin
        hready_d = 1'b1;
        state_d  = S_ERR2;
      end
      default: begin
        psel_d    = '0;
        penable_d = 1'b0;
        err_d     = 1'b0;
        hready_d  = 1'b1;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q   <= S_IDLE;
      haddr_q   <= '0;
      hwrite_q  <= 1'b0;
      idx_q     <= '0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      hrdata_q  <= '0;
      err_q     <= 1'b0;
      hready_q  <= 1'b1;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      haddr_q   <= haddr_d;
      hwrite_q  <= hwrite_d;
      idx_q     <= idx_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      hrdata_q  <= hrdata_d;
      err_q     <= err_d;
      hready_q  <= hready_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.Hrdata    = hrdata_q;
  assign bus.Hresp     = {1'b0, err_q};
  assign bus.Hreadyout = hready_q;
  assign bus.Paddr     = paddr_q;
  assign bus.Pwdata    = pwdata_q;
  assign bus.Pselx     = psel_q;
  assign bus.Pwrite    = pwrite_q;
  assign bus.Penable   = penable_q;
  assign dbg_state     = state_q;
endmodule
